// File: rtl/soc_event_collector.sv
// SoC event collector: turns per-source event pulses into event ID words,
// buffering bursts in saturating pending counters and arbitrating round-robin.
module soc_event_collector #(
    parameter int NB_SOURCES     = 8,
    parameter int EVENT_ID_WIDTH = 8,
    parameter int ID_BASE        = 0,
    parameter int CNT_WIDTH      = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [NB_SOURCES-1:0]     events_i,
    output logic                      event_fifo_valid_o,
    input  logic                      event_fifo_fulln_i,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    output logic                      overflow_o,
    output logic [EVENT_ID_WIDTH-1:0] overflow_id_o
);

    localparam int PTR_W = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    if (NB_SOURCES < 1 || NB_SOURCES > 32) begin : g_bad_nb_sources
        $error("soc_event_collector: NB_SOURCES must be in 1..32");
    end
    if ((longint'(ID_BASE) + longint'(NB_SOURCES)) > (longint'(1) << EVENT_ID_WIDTH)) begin : g_bad_id_range
        $error("soc_event_collector: ID_BASE+NB_SOURCES exceeds the event ID range");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic inc, input logic dec);
        if (inc && !dec && cnt != CNT_MAX) return cnt + CNT_WIDTH'(1);
        if (dec && !inc)                   return cnt - CNT_WIDTH'(1);
        return cnt;
    endfunction

    function automatic logic sat_drop(input logic [CNT_WIDTH-1:0] cnt,
                                      input logic inc, input logic dec);
        return inc && !dec && (cnt == CNT_MAX);
    endfunction

    function automatic logic [EVENT_ID_WIDTH-1:0] src_id(input logic [PTR_W-1:0] idx);
        return EVENT_ID_WIDTH'(ID_BASE) + EVENT_ID_WIDTH'(idx);
    endfunction

    logic [CNT_WIDTH-1:0]      cnt_p0 [NB_SOURCES];
    logic [PTR_W-1:0]          rr_ptr;
    logic                      vld_p1;
    logic [EVENT_ID_WIDTH-1:0] data_p1;
    logic                      ovf_p1;
    logic [EVENT_ID_WIDTH-1:0] ovf_id_p1;

    logic                      load_ok;
    logic                      xfer;
    logic                      grant_vld;
    logic                      grant_take;
    logic [PTR_W-1:0]          grant_idx;
    logic [NB_SOURCES-1:0]     dec;
    logic                      drop_vld;
    logic [PTR_W-1:0]          drop_idx;

    assign xfer       = vld_p1 & event_fifo_fulln_i;
    assign load_ok    = enable_i & (~vld_p1 | event_fifo_fulln_i);
    assign grant_take = grant_vld & load_ok;

    // Round-robin pick: the pending source with the smallest distance above rr_ptr wins.
    always_comb begin
        int off;
        int best_off;
        off       = 0;
        best_off  = NB_SOURCES;
        grant_idx = '0;
        for (int i = 0; i < NB_SOURCES; i++) begin
            off = i - int'(rr_ptr);
            if (off < 0) off = off + NB_SOURCES;
            if (cnt_p0[i] != '0 && off < best_off) begin
                best_off  = off;
                grant_idx = PTR_W'(i);
            end
        end
        grant_vld = (best_off < NB_SOURCES);
    end

    always_comb begin
        dec      = '0;
        drop_vld = 1'b0;
        drop_idx = '0;
        for (int i = NB_SOURCES - 1; i >= 0; i--) begin
            dec[i] = grant_take && (grant_idx == PTR_W'(i));
            if (sat_drop(cnt_p0[i], events_i[i], dec[i])) begin
                drop_vld = 1'b1;
                drop_idx = PTR_W'(i);
            end
        end
    end

    // Stage p0: pending counters
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB_SOURCES; i++) begin
            if (rst_i) cnt_p0[i] <= '0;
            else       cnt_p0[i] <= sat_cnt(cnt_p0[i], events_i[i], dec[i]);
        end
    end

    // Stage p1: output word register, arbiter pointer and overflow report
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            rr_ptr    <= '0;
            ovf_p1    <= 1'b0;
            ovf_id_p1 <= '0;
        end else begin
            if (load_ok) begin
                if (grant_vld) begin
                    vld_p1  <= 1'b1;
                    data_p1 <= src_id(grant_idx);
                    rr_ptr  <= (grant_idx == PTR_W'(NB_SOURCES - 1)) ? '0 : grant_idx + PTR_W'(1);
                end else begin
                    vld_p1 <= 1'b0;
                end
            end else if (xfer) begin
                vld_p1 <= 1'b0;
            end
            ovf_p1 <= drop_vld;
            if (drop_vld) ovf_id_p1 <= src_id(drop_idx);
        end
    end

    assign event_fifo_valid_o = vld_p1;
    assign event_fifo_data_o  = data_p1;
    assign overflow_o         = ovf_p1;
    assign overflow_id_o      = ovf_id_p1;

endmodule

// File: tb/tb_soc_event_collector.sv
// Directed self-checking bench for soc_event_collector (8 sources, ID_BASE=0x10, 2-bit counters).
module tb_soc_event_collector;

    localparam int NB   = 8;
    localparam int IDW  = 8;
    localparam int BASE = 16;
    localparam int CW   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [NB-1:0]  events;
    logic           valid;
    logic           fulln;
    logic [IDW-1:0] data;
    logic           overflow;
    logic [IDW-1:0] overflow_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soc_event_collector #(
        .NB_SOURCES     (NB),
        .EVENT_ID_WIDTH (IDW),
        .ID_BASE        (BASE),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .enable_i           (enable),
        .events_i           (events),
        .event_fifo_valid_o (valid),
        .event_fifo_fulln_i (fulln),
        .event_fifo_data_o  (data),
        .overflow_o         (overflow),
        .overflow_id_o      (overflow_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        events = '0;
        enable = 1'b1;
        fulln  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (valid !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out valid=%0b data=%h expected valid=0 data=00", valid, data);
        end
        n_checks++;
        if (overflow !== 1'b0 || overflow_id !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ovf overflow=%0b id=%h expected overflow=0 id=00", overflow, overflow_id);
        end
    endtask

    task automatic test_single;
        do_reset();
        events = 8'h08;
        tick();
        events = '0;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early valid=%0b expected 0", valid);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h13) begin
            n_fail++;
            $display("FAIL single_word valid=%0b data=%h expected valid=1 data=13", valid, data);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after valid=%0b expected 0", valid);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp_ids [3] = '{8'h10, 8'h12, 8'h15};
        do_reset();
        events = 8'h25;
        tick();
        events = '0;
        tick();
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (valid !== 1'b1 || data !== exp_ids[j]) begin
                n_fail++;
                $display("FAIL simul_word%0d valid=%0b data=%h expected valid=1 data=%h", j, valid, data, exp_ids[j]);
            end
            tick();
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drained valid=%0b expected 0", valid);
        end
        // rr_ptr should now be 6: source 7 must beat source 0.
        events = 8'h81;
        tick();
        events = '0;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h17) begin
            n_fail++;
            $display("FAIL rr_first valid=%0b data=%h expected valid=1 data=17", valid, data);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h10) begin
            n_fail++;
            $display("FAIL rr_second valid=%0b data=%h expected valid=1 data=10", valid, data);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        do_reset();
        fulln  = 1'b0;
        events = 8'h06;
        tick();
        events = '0;
        tick();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid !== 1'b1 || data !== 8'h11) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold unstable_cycles=%0d expected 0 (last valid=%0b data=%h)", bad, valid, data);
        end
        fulln = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h12) begin
            n_fail++;
            $display("FAIL bp_next valid=%0b data=%h expected valid=1 data=12", valid, data);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drained valid=%0b expected 0", valid);
        end
    endtask

    task automatic test_overflow;
        int words;
        do_reset();
        fulln  = 1'b0;
        events = 8'h10;
        for (int p = 1; p <= 5; p++) begin
            tick();
            n_checks++;
            if (overflow !== (p == 5)) begin
                n_fail++;
                $display("FAIL ovf_pulse%0d overflow=%0b expected %0b", p, overflow, (p == 5));
            end
        end
        n_checks++;
        if (overflow_id !== 8'h14) begin
            n_fail++;
            $display("FAIL ovf_id id=%h expected 14", overflow_id);
        end
        events = '0;
        tick();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_single overflow=%0b expected 0", overflow);
        end
        fulln = 1'b1;
        words = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid === 1'b1) begin
                words++;
                n_checks++;
                if (data !== 8'h14) begin
                    n_fail++;
                    $display("FAIL ovf_data word%0d data=%h expected 14", words, data);
                end
            end
            tick();
        end
        n_checks++;
        if (words != 4) begin
            n_fail++;
            $display("FAIL ovf_words delivered=%0d expected 4", words);
        end
    endtask

    task automatic test_fairness;
        int  n;
        logic found;
        do_reset();
        fulln  = 1'b1;
        events = 8'h01;
        tick();
        tick();
        tick();
        events = 8'h81;
        tick();
        events = 8'h01;
        n     = 0;
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid === 1'b1 && !found) begin
                n++;
                if (data === 8'h17) found = 1'b1;
            end
        end
        events = '0;
        n_checks++;
        if (!found || n > 2) begin
            n_fail++;
            $display("FAIL fairness found=%0b grants=%0d expected found=1 grants<=2", found, n);
        end
    endtask

    task automatic test_enable;
        int bad;
        do_reset();
        enable = 1'b0;
        events = 8'h04;
        tick();
        events = '0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_off_idle valid_cycles=%0d expected 0", bad);
        end
        enable = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h12) begin
            n_fail++;
            $display("FAIL en_resume valid=%0b data=%h expected valid=1 data=12", valid, data);
        end
        tick();
        fulln  = 1'b0;
        events = 8'h03;
        tick();
        events = '0;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h10) begin
            n_fail++;
            $display("FAIL en_load valid=%0b data=%h expected valid=1 data=10", valid, data);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h10) begin
            n_fail++;
            $display("FAIL en_hold valid=%0b data=%h expected valid=1 data=10", valid, data);
        end
        fulln = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off_xfer valid=%0b expected 0", valid);
        end
        tick();
        enable = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b1 || data !== 8'h11) begin
            n_fail++;
            $display("FAIL en_pending valid=%0b data=%h expected valid=1 data=11", valid, data);
        end
    endtask

    task automatic test_reset_midop;
        int bad;
        do_reset();
        fulln  = 1'b0;
        events = 8'h02;
        for (int p = 0; p < 5; p++) tick();
        events = '0;
        n_checks++;
        if (overflow !== 1'b1 || overflow_id !== 8'h11 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup overflow=%0b id=%h valid=%0b expected overflow=1 id=11 valid=1",
                     overflow, overflow_id, valid);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || data !== 8'h00 || overflow !== 1'b0 || overflow_id !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset valid=%0b data=%h overflow=%0b id=%h expected all 0",
                     valid, data, overflow, overflow_id);
        end
        rst   = 1'b0;
        fulln = 1'b1;
        bad   = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_silent valid_cycles=%0d expected 0", bad);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        fulln  = 1'b1;
        events = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_fairness();
        test_enable();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
